// File: rtl/pirdsp_simd_lane_acc_pkg.sv
// Shared definitions for the SIMD lane accumulator: default geometry, the
// packed P word width, the packet FSM states and a lane extract helper.
package pirdsp_simd_pkg;

  localparam int DEF_LANES  = 4;
  localparam int DEF_LANE_W = 12;
  localparam int DEF_ACC_W  = 24;
  localparam int P_W        = 48;

  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_HOLD} state_t;

  typedef logic [P_W-1:0]        p_word_t;
  typedef logic [DEF_LANE_W-1:0] lane_t;

  // Lane idx of a P word for the default lane width.
  function automatic lane_t lane_extract(input p_word_t p, input int unsigned idx);
    return lane_t'(p >> (idx * DEF_LANE_W));
  endfunction

endpackage

// File: rtl/pirdsp_simd_lane_acc_if.sv
// Beat stream in (s_*) and result vector out (m_*) for the lane accumulator.
// master: the side that produces P beats and consumes results.
// slave:  the accumulator itself.
interface pirdsp_simd_lane_acc_if
  import pirdsp_simd_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int ACC_W = DEF_ACC_W
);
  logic                     s_valid;
  logic                     s_ready;
  logic [P_W-1:0]           s_p;
  logic                     s_last;
  logic                     m_valid;
  logic                     m_ready;
  logic [LANES*ACC_W-1:0]   m_data;
  logic [LANES-1:0]         m_sat;

  modport master (
    output s_valid, s_p, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_sat
  );

  modport slave (
    input  s_valid, s_p, s_last, m_ready,
    output s_ready, m_valid, m_data, m_sat
  );
endinterface

// File: rtl/pirdsp_simd_lane_acc_lane_add.sv
// One lane: extend the lane product and the running sum to ACC_W+1 bits,
// add, then either clamp (PIRDSP_ACC_SAT_EN defined) or wrap modulo 2^ACC_W.
// Purely combinational. Without PIRDSP_ACC_SAT_EN the ovf output is constant 0.
module pirdsp_lane_add
  import pirdsp_simd_pkg::*;
#(
  parameter int LANE_W = DEF_LANE_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [LANE_W-1:0] lane,
  input  logic              mode,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  logic signed [ACC_W:0] acc_x;
  logic signed [ACC_W:0] lane_x;
  logic signed [ACC_W:0] sum_x;

  assign acc_x  = mode ? {acc[ACC_W-1], acc} : {1'b0, acc};
  assign lane_x = mode ? {{(ACC_W+1-LANE_W){lane[LANE_W-1]}}, lane}
                       : {{(ACC_W+1-LANE_W){1'b0}}, lane};
  assign sum_x  = acc_x + lane_x;

`ifdef PIRDSP_ACC_SAT_EN
  // Returns {clamped, value}. Signed overflow shows as the two top bits
  // disagreeing; unsigned operands are non-negative so only the carry matters.
  function automatic logic [ACC_W:0] sat_fn(input logic signed [ACC_W:0] s, input logic m);
    if (m) begin
      if (s[ACC_W] != s[ACC_W-1])
        return {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
    end else if (s[ACC_W]) begin
      return {1'b1, {ACC_W{1'b1}}};
    end
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  assign {ovf, sum} = sat_fn(sum_x, mode);
`else
  function automatic logic [ACC_W-1:0] wrap_fn(input logic signed [ACC_W:0] s);
    return s[ACC_W-1:0];
  endfunction

  assign sum = wrap_fn(sum_x);
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/pirdsp_simd_lane_acc.sv
// Per-lane packet accumulator behind the pirdsp2 SIMD multiplier.
// Splits each 48-bit P beat into LANES products, accumulates them per lane
// until s_last, then presents the widened vector until the consumer takes it.
// Optional macro PIRDSP_ACC_SAT_EN: saturating lanes with sticky m_sat flags;
// otherwise lanes wrap and m_sat stays 0.
module pirdsp_simd_lane_acc
  import pirdsp_simd_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int LANE_W = DEF_LANE_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   cfg_signed,
  output logic                   busy,
  pirdsp_simd_lane_acc_if.slave  bus
);

  if (LANES * LANE_W != P_W) begin : g_bad_geometry
    $error("pirdsp_simd_lane_acc: LANES*LANE_W must equal 48");
  end
  if (ACC_W < LANE_W + 1) begin : g_bad_acc_w
    $error("pirdsp_simd_lane_acc: ACC_W must be at least LANE_W+1");
  end

  state_t                 state_q, state_d;
  logic                   mode_q;
  logic [ACC_W-1:0]       acc_q  [LANES];
  logic [ACC_W-1:0]       acc_in [LANES];
  logic [ACC_W-1:0]       sum_w  [LANES];
  logic [LANES-1:0]       sat_q;
  logic [LANES-1:0]       ovf_w;
  logic [LANES-1:0]       sat_nxt;
  logic [LANES*ACC_W-1:0] sum_pk;
  logic [LANES*ACC_W-1:0] m_data_q;
  logic [LANES-1:0]       m_sat_q;
  logic                   s_ready_c, m_valid_c, busy_c;
  logic                   first, accept, mode_eff;

  // A beat taken in IDLE opens a packet: it uses the live cfg_signed and
  // discards whatever the accumulators held before.
  assign first    = (state_q == ST_IDLE);
  assign accept   = bus.s_valid & s_ready_c;
  assign mode_eff = first ? cfg_signed : mode_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign acc_in[i]  = first ? '0 : acc_q[i];
    assign sat_nxt[i] = (first ? 1'b0 : sat_q[i]) | ovf_w[i];
    assign sum_pk[i*ACC_W +: ACC_W] = sum_w[i];

    pirdsp_lane_add #(
      .LANE_W (LANE_W),
      .ACC_W  (ACC_W)
    ) u_add (
      .acc  (acc_in[i]),
      .lane (bus.s_p[i*LANE_W +: LANE_W]),
      .mode (mode_eff),
      .sum  (sum_w[i]),
      .ovf  (ovf_w[i])
    );
  end

  // Packet state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Packet state transitions.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ACC: if (accept) state_d = bus.s_last ? ST_HOLD : ST_ACC;
      ST_HOLD:         if (bus.m_ready) state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    s_ready_c = (state_q != ST_HOLD);
    m_valid_c = (state_q == ST_HOLD);
    busy_c    = (state_q != ST_IDLE);
  end

  // Accumulate stage: running sums, sticky clamp flags and the packet mode.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
      sat_q  <= '0;
      mode_q <= 1'b0;
    end else if (accept) begin
      for (int i = 0; i < LANES; i++) acc_q[i] <= sum_w[i];
      sat_q <= sat_nxt;
      if (first) mode_q <= cfg_signed;
    end
  end

  // Result stage: captured only when the last beat lands, held until the next one.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_data_q <= '0;
      m_sat_q  <= '0;
    end else if (accept && bus.s_last) begin
      m_data_q <= sum_pk;
      m_sat_q  <= sat_nxt;
    end
  end

  assign bus.s_ready = s_ready_c;
  assign bus.m_valid = m_valid_c;
  assign bus.m_data  = m_data_q;
  assign bus.m_sat   = m_sat_q;
  assign busy        = busy_c;

endmodule

// File: tb/tb_pirdsp_simd_lane_acc.sv
// Directed bench for pirdsp_simd_lane_acc (default geometry 4 x 12 -> 24).
// Expected values follow PIRDSP_ACC_SAT_EN when it is defined for the build.
module tb_pirdsp_simd_lane_acc;

  logic CLK = 1'b0;
  logic RST_N;
  logic cfg_signed;
  logic busy;

  int n_checks = 0;
  int n_err    = 0;

  pirdsp_simd_lane_acc_if #(.LANES(4), .ACC_W(24)) bus ();

  pirdsp_simd_lane_acc #(.LANES(4), .LANE_W(12), .ACC_W(24)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .cfg_signed (cfg_signed),
    .busy       (busy),
    .bus        (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat and return #1 after the edge that accepted it.
  task automatic beat(input logic [47:0] p, input logic last);
    int guard;
    bus.s_valid = 1'b1;
    bus.s_p     = p;
    bus.s_last  = last;
    guard = 0;
    while (!bus.s_ready && guard < 50) begin
      @(posedge CLK); #1;
      guard++;
    end
    if (guard == 50) check("beat_ready_timeout", {95'd0, bus.s_ready}, 96'd1);
    @(posedge CLK); #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  // Accept the pending result with a one-cycle m_ready pulse.
  task automatic take();
    bus.m_ready = 1'b1;
    @(posedge CLK); #1;
    bus.m_ready = 1'b0;
  endtask

  logic [95:0] held;
  logic [23:0] exp_l0, exp_l1;
  logic [3:0]  exp_sat;
  int          plen [4];
  int          exp_sum [4];
  int          pk, bj, results, lows, accepted;
  logic        acc_now;

  initial begin
    RST_N       = 1'b0;
    cfg_signed  = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_p     = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_m_valid", {95'd0, bus.m_valid}, 96'd0);
    check("rst_m_data", bus.m_data, 96'd0);
    check("rst_m_sat", {92'd0, bus.m_sat}, 96'd0);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    check("rst_s_ready", {95'd0, bus.s_ready}, 96'd1);
    check("rst_busy", {95'd0, busy}, 96'd0);

    // 1: signed 3-beat packet in lane0: 5 + (-2) + 3 = 6; mode latched on first beat
    cfg_signed = 1'b1;
    beat(48'h000_000_000_005, 1'b0);
    cfg_signed = 1'b0;
    beat(48'h000_000_000_FFE, 1'b0);
    check("t1_mid_m_valid", {95'd0, bus.m_valid}, 96'd0);
    check("t1_mid_busy", {95'd0, busy}, 96'd1);
    beat(48'h000_000_000_003, 1'b1);
    check("t1_m_valid", {95'd0, bus.m_valid}, 96'd1);
    check("t1_m_data", bus.m_data, 96'h000000_000000_000000_000006);
    check("t1_m_sat", {92'd0, bus.m_sat}, 96'd0);
    check("t1_hold_s_ready", {95'd0, bus.s_ready}, 96'd0);
    take();
    check("t1_after_m_valid", {95'd0, bus.m_valid}, 96'd0);
    check("t1_after_s_ready", {95'd0, bus.s_ready}, 96'd1);
    check("t1_after_busy", {95'd0, busy}, 96'd0);
    check("t1_after_m_data", bus.m_data, 96'h000000_000000_000000_000006);

    // 2: unsigned single beat, every lane 0xFFF stays 0x000FFF
    cfg_signed = 1'b0;
    beat(48'hFFF_FFF_FFF_FFF, 1'b1);
    check("t2_m_valid", {95'd0, bus.m_valid}, 96'd1);
    check("t2_m_data", bus.m_data, 96'h000FFF_000FFF_000FFF_000FFF);
    check("t2_m_sat", {92'd0, bus.m_sat}, 96'd0);
    take();
    check("t2_busy_idle", {95'd0, busy}, 96'd0);

    // 3: consumer stalls 5 cycles; beats offered meanwhile must be ignored
    cfg_signed = 1'b1;
    beat(48'h123_123_123_123, 1'b1);
    held = bus.m_data;
    check("t3_m_data", held, 96'h000123_000123_000123_000123);
    bus.s_valid = 1'b1;
    bus.s_p     = 48'h7FF_7FF_7FF_7FF;
    bus.s_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK); #1;
      check("t3_stall_m_valid", {95'd0, bus.m_valid}, 96'd1);
      check("t3_stall_s_ready", {95'd0, bus.s_ready}, 96'd0);
      check("t3_stall_m_data", bus.m_data, 96'h000123_000123_000123_000123);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    take();
    beat(48'h001_001_001_001, 1'b1);
    check("t3_next_m_data", bus.m_data, 96'h000001_000001_000001_000001);
    take();

    // 4: 4200 signed beats, lane0 = -2048, lane1 = +2047, both beyond 24-bit range
    cfg_signed = 1'b1;
    for (int k = 0; k < 4200; k++) beat(48'h000_000_7FF_800, k == 4199);
`ifdef PIRDSP_ACC_SAT_EN
    exp_l0  = 24'h800000;
    exp_l1  = 24'h7FFFFF;
    exp_sat = 4'b0011;
`else
    exp_l0  = 24'h7CC000;   // -8601600 mod 2^24
    exp_l1  = 24'h832F98;   //  8597400 mod 2^24
    exp_sat = 4'b0000;
`endif
    check("t4_m_valid", {95'd0, bus.m_valid}, 96'd1);
    check("t4_m_data", bus.m_data, {48'd0, exp_l1, exp_l0});
    check("t4_m_sat", {92'd0, bus.m_sat}, {92'd0, exp_sat});
    take();

    // 5: reset in the middle of a packet
    cfg_signed = 1'b1;
    beat(48'h000_7FF_000_000, 1'b0);
    beat(48'h000_7FF_000_000, 1'b0);
    RST_N = 1'b0;
    #1;
    check("t5_rst_busy", {95'd0, busy}, 96'd0);
    check("t5_rst_m_valid", {95'd0, bus.m_valid}, 96'd0);
    check("t5_rst_m_data", bus.m_data, 96'd0);
    check("t5_rst_m_sat", {92'd0, bus.m_sat}, 96'd0);
    RST_N = 1'b1;
    #1;
    check("t5_rel_s_ready", {95'd0, bus.s_ready}, 96'd1);
    beat(48'h000_001_000_000, 1'b1);
    check("t5_m_valid", {95'd0, bus.m_valid}, 96'd1);
    check("t5_m_data", bus.m_data, 96'h000000_000001_000000_000000);
    take();

    // 6: back-to-back packets with the consumer always ready
    plen[0] = 3; plen[1] = 1; plen[2] = 2; plen[3] = 4;
    for (int k = 0; k < 4; k++) begin
      exp_sum[k] = 0;
      for (int j = 0; j < plen[k]; j++) exp_sum[k] += k * 16 + j + 1;
    end
    cfg_signed  = 1'b0;
    pk = 0; bj = 0; results = 0; lows = 0; accepted = 0;
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_p     = {24'd0, 12'h001, 12'(1)};
    bus.s_last  = (plen[0] == 1);
    for (int cyc = 0; cyc < 100 && results < 4; cyc++) begin
      if (bus.m_valid) begin
        check("t6_lane0_sum", {72'd0, bus.m_data[23:0]}, 96'(exp_sum[results]));
        check("t6_lane1_cnt", {72'd0, bus.m_data[47:24]}, 96'(plen[results]));
        results++;
      end
      if (!bus.s_ready) lows++;
      acc_now = bus.s_ready && (pk < 4);
      @(posedge CLK); #1;
      if (acc_now) begin
        accepted++;
        bj++;
        if (bj == plen[pk]) begin
          pk++;
          bj = 0;
        end
      end
      if (pk < 4) begin
        bus.s_p    = {24'd0, 12'h001, 12'(pk * 16 + bj + 1)};
        bus.s_last = (bj == plen[pk] - 1);
      end else begin
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
      end
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    check("t6_results", 96'(results), 96'd4);
    check("t6_ready_low_cycles", 96'(lows), 96'd4);
    check("t6_beats_accepted", 96'(accepted), 96'd10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
